// File: rtl/keyboard_debounce_multi.sv
// ---------------------------------------------------------------------------
// keyboard_debounce_multi
//
// Multi-channel push-button front end for the Basys3 board. Each raw button
// is brought into the BasysCLK domain with a two-flop synchroniser and then
// debounced with its own stability counter. The block reports the debounced
// level of every channel, one-cycle press and release pulses, and a
// priority-encoded code for the lowest-numbered key that was just pressed.
// Any ReleasePulse bit is clean enough to drive a CPU single-step directly.
//
// Optional feature (macro KEYBOARD_REPEAT_EN):
//   When defined, every channel gains an auto-repeat FSM. A held key emits
//   extra PressPulse pulses, the first REPEAT_DELAY cycles after the original
//   press and then one every REPEAT_PERIOD cycles until the key is released.
//   When undefined, PressPulse fires once per debounced press and the
//   REPEAT_* parameters have no effect.
//
// Parameters:
//   N               number of button channels (1..16)
//   DEBOUNCE_CYCLES consecutive stable synchronised samples needed to accept
//                   a level change (>= 1)
//   REPEAT_DELAY    hold time before the first auto-repeat pulse (>= 1)
//   REPEAT_PERIOD   spacing of later auto-repeat pulses (>= 1)
//
// Ports:
//   BasysCLK      in   1      board clock, all state updates on rising edge
//   Reset         in   1      asynchronous, active-high reset
//   Button        in   N      raw, asynchronous, bouncing button levels
//   Stable        out  N      debounced level per channel
//   PressPulse    out  N      one-cycle pulse when Stable rises (plus repeats)
//   ReleasePulse  out  N      one-cycle pulse when Stable falls
//   KeyValid      out  1      OR of all PressPulse bits
//   KeyCode       out  KW     lowest index with PressPulse high, else 0
//                             (KW = clog2(N), minimum 1)
//
// Timing: a change on Button that arrives before edge 0 and then holds shows
// up on Stable (together with its pulse) at edge 2+DEBOUNCE_CYCLES. The extra
// edge beyond the synchroniser and counter comes from registering Stable and
// the pulses together, so a pulse is always aligned with the Stable change it
// reports.
// ---------------------------------------------------------------------------
module keyboard_debounce_multi #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                                BasysCLK,
  input  logic                                Reset,
  input  logic [N-1:0]                        Button,
  output logic [N-1:0]                        Stable,
  output logic [N-1:0]                        PressPulse,
  output logic [N-1:0]                        ReleasePulse,
  output logic                                KeyValid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] KeyCode
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef KEYBOARD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rptState_e;
`else
  logic unusedRepeatParams;
  assign unusedRepeatParams = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  for (genvar gi = 0; gi < N; gi++) begin : gChan
    logic          s1_q;
    logic          s2_q;
    logic          deb_q;
    logic          deb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          stable_q;
    logic          press_q;
    logic          press_d;
    logic          release_q;
    logic          release_d;
    logic          riseEvt;
    logic          fallEvt;
    logic          repeatFire;

    // Synchroniser, debounce state and the output register stage.
    // deb_q is the accepted level; stable_q trails it by one cycle so that
    // the pulses below land in the same cycle as the Stable change.
    always_ff @(posedge BasysCLK or posedge Reset) begin
      if (Reset) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        deb_q     <= 1'b0;
        cnt_q     <= '0;
        stable_q  <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        s1_q      <= Button[gi];
        s2_q      <= s1_q;
        deb_q     <= deb_d;
        cnt_q     <= cnt_d;
        stable_q  <= deb_q;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Stability counter: any sample matching the accepted level restarts the
    // count, so the counter stops at CNT_LAST and can never wrap.
    always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (s2_q != deb_q) begin
        if (cnt_q == CNT_LAST) begin
          deb_d = ~deb_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    assign riseEvt = deb_q & ~stable_q;
    assign fallEvt = ~deb_q & stable_q;

`ifdef KEYBOARD_REPEAT_EN
    rptState_e     state_q;
    rptState_e     state_d;
    logic [RW-1:0] rcnt_q;
    logic [RW-1:0] rcnt_d;

    always_ff @(posedge BasysCLK or posedge Reset) begin
      if (Reset) begin
        state_q <= RPT_IDLE;
        rcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
      end
    end

    // The FSM leaves IDLE in the same cycle the original press pulse is
    // registered, so counting starts from that pulse. A release always wins
    // over a repeat that would otherwise fire in the same cycle.
    always_comb begin
      state_d    = state_q;
      rcnt_d     = rcnt_q;
      repeatFire = 1'b0;
      case (state_q)
        RPT_IDLE: begin
          if (riseEvt) begin
            state_d = RPT_DELAY;
            rcnt_d  = '0;
          end
        end
        RPT_DELAY: begin
          if (fallEvt) begin
            state_d = RPT_IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == DLY_LAST) begin
            state_d    = RPT_REPEAT;
            rcnt_d     = '0;
            repeatFire = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (fallEvt) begin
            state_d = RPT_IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == PER_LAST) begin
            rcnt_d     = '0;
            repeatFire = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = RPT_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
`else
    assign repeatFire = 1'b0;
`endif

    assign press_d   = riseEvt | repeatFire;
    assign release_d = fallEvt;

    assign Stable[gi]       = stable_q;
    assign PressPulse[gi]   = press_q;
    assign ReleasePulse[gi] = release_q;
  end

  // Key reporting works straight off the registered pulses; scanning from
  // the top down lets the lowest set index overwrite the others.
  always_comb begin
    KeyValid = |PressPulse;
    KeyCode  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (PressPulse[i]) begin
        KeyCode = KW'(i);
      end
    end
  end

endmodule

// File: tb/tb_keyboard_debounce_multi.sv
// Directed bench for keyboard_debounce_multi with N=4 and DEBOUNCE_CYCLES=4,
// so a held change applied before edge 0 appears at edge 6.
module tb_keyboard_debounce_multi;

   logic       BasysCLK;
   logic       Reset;
   logic [3:0] Button;
   logic [3:0] Stable;
   logic [3:0] PressPulse;
   logic [3:0] ReleasePulse;
   logic       KeyValid;
   logic [1:0] KeyCode;

   int checkCount;
   int errorCount;
   bit repeatEn;

   keyboard_debounce_multi #(
      .N              (4),
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (10),
      .REPEAT_PERIOD  (5)
   ) dut (
      .BasysCLK    (BasysCLK),
      .Reset       (Reset),
      .Button      (Button),
      .Stable      (Stable),
      .PressPulse  (PressPulse),
      .ReleasePulse(ReleasePulse),
      .KeyValid    (KeyValid),
      .KeyCode     (KeyCode)
   );

   // Free-running 100 MHz board clock.
   initial begin
      BasysCLK = 1'b0;
      forever #5 BasysCLK = ~BasysCLK;
   end

   // Inputs change on the falling edge, so the next rising edge is "edge 0".
   task automatic applyStimulus(input logic [3:0] btn);
      Button = btn;
   endtask

   // Advance one rising edge and come back to the falling edge to observe it.
   task automatic stepCycle(input int n);
      repeat (n) begin
         @(posedge BasysCLK);
         @(negedge BasysCLK);
      end
   endtask

   // Compare every output against hand-computed values in one shot.
   task automatic checkOutput(input string tag, input logic [3:0] expStable,
                              input logic [3:0] expPress, input logic [3:0] expRelease,
                              input logic expValid, input logic [1:0] expCode);
      logic [14:0] observed;
      logic [14:0] expected;
      observed = {Stable, PressPulse, ReleasePulse, KeyValid, KeyCode};
      expected = {expStable, expPress, expRelease, expValid, expCode};
      checkCount++;
      assert (observed === expected) else begin
         errorCount++;
         $error("[TB] FAIL %s: observed stable=%b press=%b release=%b valid=%b code=%0d, expected stable=%b press=%b release=%b valid=%b code=%0d",
                tag, Stable, PressPulse, ReleasePulse, KeyValid, KeyCode,
                expStable, expPress, expRelease, expValid, expCode);
      end
   endtask

   // The whole scenario runs as one straight-line sequence of directed steps.
   initial begin
      logic [3:0] expPress;
      logic [3:0] expStable;
      logic [3:0] expRelease;
      checkCount = 0;
      errorCount = 0;
`ifdef KEYBOARD_REPEAT_EN
      repeatEn = 1'b1;
`else
      repeatEn = 1'b0;
`endif
      Reset  = 1'b1;
      Button = 4'b0000;

      // Reset state, then a few idle cycles after release.
      stepCycle(2);
      checkOutput("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
      Reset = 1'b0;
      stepCycle(3);
      checkOutput("idle", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);

      // Clean press on channel 0: nothing at edge 5, pulse at edge 6 only.
      applyStimulus(4'b0001);
      stepCycle(6);
      checkOutput("press0 e5", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
      stepCycle(1);
      checkOutput("press0 e6", 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0);
      stepCycle(1);
      checkOutput("press0 e7", 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0);

      // Bounce on channel 1: toggling never completes a count.
      applyStimulus(4'b0011);
      stepCycle(1);
      checkOutput("bounce t0", 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0);
      applyStimulus(4'b0001);
      stepCycle(1);
      checkOutput("bounce t1", 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0);
      applyStimulus(4'b0011);
      stepCycle(1);
      checkOutput("bounce t2", 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0);
      applyStimulus(4'b0001);
      stepCycle(1);
      checkOutput("bounce t3", 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0);
      applyStimulus(4'b0011);
      stepCycle(6);
      checkOutput("bounce e5", 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0);
      stepCycle(1);
      checkOutput("bounce e6", 4'b0011, 4'b0010, 4'b0000, 1'b1, 2'd1);

      // Channels 2 and 3 pressed together, then released together.
      applyStimulus(4'b1111);
      stepCycle(7);
      checkOutput("press23", 4'b1111, 4'b1100, 4'b0000, 1'b1, 2'd2);
      stepCycle(1);
      checkOutput("press23 after", 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0);
      applyStimulus(4'b0011);
      stepCycle(6);
      checkOutput("release23 e5", 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0);
      stepCycle(1);
      checkOutput("release23 e6", 4'b0011, 4'b0000, 4'b1100, 1'b0, 2'd0);
      stepCycle(1);
      checkOutput("release23 e7", 4'b0011, 4'b0000, 4'b0000, 1'b0, 2'd0);

      // Release channel 1 alone, then press 1 and 3 together for priority.
      applyStimulus(4'b0001);
      stepCycle(7);
      checkOutput("release1", 4'b0001, 4'b0000, 4'b0010, 1'b0, 2'd0);
      applyStimulus(4'b1011);
      stepCycle(7);
      checkOutput("priority", 4'b1011, 4'b1010, 4'b0000, 1'b1, 2'd1);
      stepCycle(1);
      checkOutput("priority after", 4'b1011, 4'b0000, 4'b0000, 1'b0, 2'd0);

      // Reset while channel 2 sits at count 2 of a pending press.
      applyStimulus(4'b1111);
      stepCycle(4);
      checkOutput("pending", 4'b1011, 4'b0000, 4'b0000, 1'b0, 2'd0);
      Reset = 1'b1;
      #1;
      checkOutput("async reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
      stepCycle(2);
      checkOutput("held reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
      Reset = 1'b0;
      stepCycle(6);
      checkOutput("post reset e5", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
      stepCycle(1);
      checkOutput("post reset e6", 4'b1111, 4'b1111, 4'b0000, 1'b1, 2'd0);
      stepCycle(1);
      checkOutput("post reset e7", 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0);

      // Release everything so channel 0 starts the hold test from rest.
      applyStimulus(4'b0000);
      stepCycle(7);
      checkOutput("release all", 4'b0000, 4'b0000, 4'b1111, 1'b0, 2'd0);

      // Hold channel 0 and drop it so the release pulse lands at t+40, the
      // same cycle a repeat would otherwise be due.
      applyStimulus(4'b0001);
      stepCycle(7);
      checkOutput("hold t", 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0);
      for (int k = 1; k <= 50; k++) begin
         stepCycle(1);
         expStable  = (k < 40) ? 4'b0001 : 4'b0000;
         expRelease = (k == 40) ? 4'b0001 : 4'b0000;
         expPress   = (repeatEn && k >= 10 && k <= 35 && (k % 5) == 0) ? 4'b0001 : 4'b0000;
         checkOutput($sformatf("hold t+%0d", k), expStable, expPress, expRelease, expPress[0], 2'd0);
         if (k == 33) begin
            applyStimulus(4'b0000);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
